// File: rtl/board_move_controller_pkg.sv
// Shared definitions for the tic-tac-toe board/turn controller: cell codes,
// FSM state encodings, board geometry and a board-full helper.
package board_move_controller_pkg;

  localparam int unsigned N_CELLS   = 9;
  localparam int unsigned BOARD_W   = 2 * N_CELLS;
  localparam int unsigned POS_W     = 4;

  typedef enum logic [1:0] {
    CELL_EMPTY    = 2'b00,
    CELL_PLAYER   = 2'b01,
    CELL_COMPUTER = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    S_PLAYER   = 2'b00,
    S_COMPUTER = 2'b01,
    S_CHECK    = 2'b10,
    S_OVER     = 2'b11
  } state_t;

  // A board is full once no cell holds the empty code.
  function automatic logic board_full(input logic [BOARD_W-1:0] b);
    logic full;
    full = 1'b1;
    for (int k = 0; k < N_CELLS; k++) begin
      if (b[2*k +: 2] == CELL_EMPTY) begin
        full = 1'b0;
      end else begin
        full = full;
      end
    end
    return full;
  endfunction

endpackage

// File: rtl/board_move_controller_move_validator.sv
// Combinational move check: a target cell is legal when it exists (0..8) and is empty.
// The one-hot write enable selects the cell to be written; it is all-zero when illegal.
module move_validator
  import board_move_controller_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [POS_W-1:0]   pos,
  output logic               legal,
  output logic [N_CELLS-1:0] write_en
);

  // Positions above 8 never match any cell index, so they fall out as illegal.
  always_comb begin
    write_en = {N_CELLS{1'b0}};
    for (int k = 0; k < N_CELLS; k++) begin
      write_en[k] = (pos == POS_W'(k)) && (board[2*k +: 2] == CELL_EMPTY);
    end
    legal = |write_en;
  end

endmodule

// File: rtl/board_move_controller.sv
// Tic-tac-toe board owner and turn controller: validates player/computer moves,
// writes the board, and ends the game on an external win result or a full board.
module board_move_controller
  import board_move_controller_pkg::*;
#(
  parameter logic [1:0] PLAYER_CODE   = 2'b01,
  parameter logic [1:0] COMPUTER_CODE = 2'b10,
  parameter bit         PLAYER_FIRST  = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               new_game,
  input  logic               play,
  input  logic [POS_W-1:0]   player_pos,
  input  logic               pc,
  input  logic [POS_W-1:0]   computer_pos,
  input  logic               win,
  input  logic [1:0]         who,
  output logic [BOARD_W-1:0] board,
  output logic               turn,
  output logic               illegal_move,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam state_t START_STATE = PLAYER_FIRST ? S_PLAYER : S_COMPUTER;

  state_t               state_q;
  state_t               state_d;
  logic [BOARD_W-1:0]   board_q;
  logic [BOARD_W-1:0]   board_d;
  logic                 turn_q;
  logic                 turn_d;
  logic                 illegal_q;
  logic                 illegal_d;
  logic                 over_q;
  logic                 over_d;
  logic [1:0]           winner_q;
  logic [1:0]           winner_d;
  logic                 last_player_q;
  logic                 last_player_d;

  logic                 req;
  logic [POS_W-1:0]     sel_pos;
  logic [1:0]           sel_code;
  logic                 legal;
  logic [N_CELLS-1:0]   write_en;
  logic [BOARD_W-1:0]   board_written;

  // Only the request belonging to the current mover state is considered.
  always_comb begin
    req      = 1'b0;
    sel_pos  = player_pos;
    sel_code = PLAYER_CODE;
    case (state_q)
      S_PLAYER: begin
        req      = play;
        sel_pos  = player_pos;
        sel_code = PLAYER_CODE;
      end
      S_COMPUTER: begin
        req      = pc;
        sel_pos  = computer_pos;
        sel_code = COMPUTER_CODE;
      end
      default: begin
        req      = 1'b0;
        sel_pos  = player_pos;
        sel_code = PLAYER_CODE;
      end
    endcase
  end

  move_validator u_move_validator (
    .board    (board_q),
    .pos      (sel_pos),
    .legal    (legal),
    .write_en (write_en)
  );

  always_comb begin
    board_written = board_q;
    for (int k = 0; k < N_CELLS; k++) begin
      if (write_en[k]) begin
        board_written[2*k +: 2] = sel_code;
      end else begin
        board_written[2*k +: 2] = board_q[2*k +: 2];
      end
    end
  end

  // Next-state and next-output logic; illegal_move is a single-cycle pulse by default.
  always_comb begin
    state_d       = state_q;
    board_d       = board_q;
    turn_d        = turn_q;
    illegal_d     = 1'b0;
    over_d        = over_q;
    winner_d      = winner_q;
    last_player_d = last_player_q;
    case (state_q)
      S_PLAYER, S_COMPUTER: begin
        if (req && legal) begin
          board_d       = board_written;
          state_d       = S_CHECK;
          last_player_d = (state_q == S_PLAYER);
        end else if (req) begin
          illegal_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_CHECK: begin
        if (win) begin
          winner_d = who;
          over_d   = 1'b1;
          state_d  = S_OVER;
        end else if (board_full(board_q)) begin
          winner_d = 2'b00;
          over_d   = 1'b1;
          state_d  = S_OVER;
        end else if (last_player_q) begin
          turn_d  = 1'b0;
          state_d = S_COMPUTER;
        end else begin
          turn_d  = 1'b1;
          state_d = S_PLAYER;
        end
      end
      S_OVER: begin
        if (new_game) begin
          board_d  = {BOARD_W{1'b0}};
          winner_d = 2'b00;
          over_d   = 1'b0;
          turn_d   = PLAYER_FIRST;
          state_d  = START_STATE;
        end else begin
          state_d = S_OVER;
        end
      end
      default: begin
        state_d = START_STATE;
      end
    endcase
  end

  // State and output registers; reset wins over every request in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= START_STATE;
      board_q       <= {BOARD_W{1'b0}};
      turn_q        <= PLAYER_FIRST;
      illegal_q     <= 1'b0;
      over_q        <= 1'b0;
      winner_q      <= 2'b00;
      last_player_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      board_q       <= board_d;
      turn_q        <= turn_d;
      illegal_q     <= illegal_d;
      over_q        <= over_d;
      winner_q      <= winner_d;
      last_player_q <= last_player_d;
    end
  end

  assign board        = board_q;
  assign turn         = turn_q;
  assign illegal_move = illegal_q;
  assign game_over    = over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_board_move_controller.sv
// Directed bench for board_move_controller with a behavioural winner-detect model
// closing the board -> win/who loop.
module tb_board_move_controller;

  logic        clock;
  logic        reset;
  logic        new_game;
  logic        play;
  logic [3:0]  player_pos;
  logic        pc;
  logic [3:0]  computer_pos;
  logic        win;
  logic [1:0]  who;
  logic [17:0] board;
  logic        turn;
  logic        illegal_move;
  logic        game_over;
  logic [1:0]  winner;

  int n_checks;
  int n_errors;

  board_move_controller dut (
    .clock        (clock),
    .reset        (reset),
    .new_game     (new_game),
    .play         (play),
    .player_pos   (player_pos),
    .pc           (pc),
    .computer_pos (computer_pos),
    .win          (win),
    .who          (who),
    .board        (board),
    .turn         (turn),
    .illegal_move (illegal_move),
    .game_over    (game_over),
    .winner       (winner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Winner-detect model: three equal non-empty cells on any of the 8 lines.
  function automatic logic [2:0] detect(input logic [17:0] b);
    int lines [8][3];
    logic [1:0] a, c, d;
    lines = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
              '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    for (int i = 0; i < 8; i++) begin
      a = b[2*lines[i][0] +: 2];
      c = b[2*lines[i][1] +: 2];
      d = b[2*lines[i][2] +: 2];
      if (a != 2'b00 && a == c && a == d) return {1'b1, a};
    end
    return 3'b000;
  endfunction

  always_comb begin
    {win, who} = detect(board);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Pulse one request, then let the S_CHECK cycle resolve; returns on a negedge.
  task automatic move(input bit by_player, input logic [3:0] pos);
    @(negedge clock);
    if (by_player) begin play = 1'b1; player_pos = pos; end
    else begin pc = 1'b1; computer_pos = pos; end
    @(negedge clock);
    play = 1'b0;
    pc   = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1; new_game = 1'b0; play = 1'b0; pc = 1'b0;
    player_pos = 4'd0; computer_pos = 4'd0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst_board", 32'(board), 32'h0);
    check("rst_turn", 32'(turn), 32'h1);
    check("rst_illegal", 32'(illegal_move), 32'h0);
    check("rst_over", 32'(game_over), 32'h0);
    check("rst_winner", 32'(winner), 32'h0);

    // 1: player to 4; a pc request during S_CHECK is dropped
    play = 1'b1; player_pos = 4'd4;
    @(negedge clock);
    play = 1'b0;
    check("t1_board", 32'(board), 32'h100);
    check("t1_turn_hold", 32'(turn), 32'h1);
    check("t1_illegal", 32'(illegal_move), 32'h0);
    pc = 1'b1; computer_pos = 4'd5;
    @(negedge clock);
    pc = 1'b0;
    check("t1_turn", 32'(turn), 32'h0);
    check("t1_check_drop", 32'(board), 32'h100);
    check("t1_check_noill", 32'(illegal_move), 32'h0);

    // 2: computer onto occupied cell 4
    pc = 1'b1; computer_pos = 4'd4;
    @(negedge clock);
    pc = 1'b0;
    check("t2_illegal", 32'(illegal_move), 32'h1);
    check("t2_board", 32'(board), 32'h100);
    @(negedge clock);
    check("t2_pulse_end", 32'(illegal_move), 32'h0);
    check("t2_turn", 32'(turn), 32'h0);
    // still computer's turn: play ignored, legal pc accepted
    play = 1'b1; player_pos = 4'd0;
    @(negedge clock);
    play = 1'b0;
    check("t2_play_ign", 32'(board), 32'h100);
    check("t2_play_noill", 32'(illegal_move), 32'h0);
    move(1'b0, 4'd0);
    check("t2_pc_board", 32'(board), 32'h102);
    check("t2_turn_back", 32'(turn), 32'h1);

    // 3: out-of-range player positions, and pc on the player's turn
    do_reset();
    play = 1'b1; player_pos = 4'd9;
    @(negedge clock);
    play = 1'b0;
    check("t3_ill9", 32'(illegal_move), 32'h1);
    check("t3_board9", 32'(board), 32'h0);
    play = 1'b1; player_pos = 4'd15;
    @(negedge clock);
    play = 1'b0;
    check("t3_ill15", 32'(illegal_move), 32'h1);
    pc = 1'b1; computer_pos = 4'd3;
    @(negedge clock);
    pc = 1'b0;
    check("t3_pc_ign", 32'(board), 32'h0);
    check("t3_pc_noill", 32'(illegal_move), 32'h0);
    check("t3_turn", 32'(turn), 32'h1);

    // 4: player wins on the top row
    do_reset();
    move(1'b1, 4'd0);
    move(1'b0, 4'd3);
    move(1'b1, 4'd1);
    move(1'b0, 4'd4);
    check("t4_pre_over", 32'(game_over), 32'h0);
    @(negedge clock);
    play = 1'b1; player_pos = 4'd2;
    @(negedge clock);
    play = 1'b0;
    check("t4_win_board", 32'(board), 32'h295);
    check("t4_over_n1", 32'(game_over), 32'h0);
    @(negedge clock);
    check("t4_over", 32'(game_over), 32'h1);
    check("t4_winner", 32'(winner), 32'h1);
    play = 1'b1; player_pos = 4'd5; pc = 1'b1; computer_pos = 4'd6;
    @(negedge clock);
    play = 1'b0; pc = 1'b0;
    check("t4_ign_board", 32'(board), 32'h295);
    check("t4_ign_ill", 32'(illegal_move), 32'h0);
    check("t4_ign_over", 32'(game_over), 32'h1);

    // 5: draw, then new_game
    do_reset();
    move(1'b1, 4'd0); move(1'b0, 4'd1);
    move(1'b1, 4'd2); move(1'b0, 4'd4);
    move(1'b1, 4'd3); move(1'b0, 4'd5);
    move(1'b1, 4'd7); move(1'b0, 4'd6);
    check("t5_pre_over", 32'(game_over), 32'h0);
    move(1'b1, 4'd8);
    check("t5_board", 32'(board), 32'h16A59);
    check("t5_over", 32'(game_over), 32'h1);
    check("t5_winner", 32'(winner), 32'h0);
    new_game = 1'b1;
    @(negedge clock);
    new_game = 1'b0;
    check("t5_ng_board", 32'(board), 32'h0);
    check("t5_ng_over", 32'(game_over), 32'h0);
    check("t5_ng_turn", 32'(turn), 32'h1);
    move(1'b1, 4'd8);
    check("t5_ng_play", 32'(board), 32'h10000);
    check("t5_ng_turn2", 32'(turn), 32'h0);

    // 6: reset in the same cycle as a legal request
    reset = 1'b1; pc = 1'b1; computer_pos = 4'd2;
    @(negedge clock);
    reset = 1'b0; pc = 1'b0;
    check("t6_board_mid", 32'(board), 32'h0);
    check("t6_turn_mid", 32'(turn), 32'h1);
    reset = 1'b1; play = 1'b1; player_pos = 4'd4;
    @(negedge clock);
    reset = 1'b0; play = 1'b0;
    check("t6_board", 32'(board), 32'h0);
    check("t6_illegal", 32'(illegal_move), 32'h0);
    move(1'b1, 4'd4);
    check("t6_state_player", 32'(board), 32'h100);
    check("t6_turn", 32'(turn), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
